add_pipe_core: RTL and testbench



---
 rtl/add_pipe_pkg.sv | 12 +
 rtl/add_pipe_if.sv | 28 ++
 rtl/add_pipe_stage.sv | 43 ++++
 rtl/add_pipe_core.sv | 121 ++++++++++++
 tb/tb_add_pipe_core.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/add_pipe_pkg.sv
// Shared types and limits for the pipelined add/subtract core.
// The per-stage payload struct depends on WIDTH, so it is declared inside add_pipe_core.
package add_pipe_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } add_op_e;

  localparam int MAX_PIPE_STAGES = 8;

endpackage

// File: rtl/add_pipe_if.sv
// Operand/result bus of add_pipe_core: an input channel and an output channel.
// Handshake: a transfer happens on a rising edge where valid && ready; valid must not depend on ready.
interface add_pipe_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic             in_op;
  logic [WIDTH-1:0] ina;
  logic [WIDTH-1:0] inb;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out;
  logic             out_op;

  modport master (
    output in_valid, in_op, ina, inb, out_ready,
    input  in_ready, out_valid, out, out_op
  );

  modport slave (
    input  in_valid, in_op, ina, inb, out_ready,
    output in_ready, out_valid, out, out_op
  );

endinterface

// File: rtl/add_pipe_stage.sv
// One register slice of the pipeline: a valid bit plus a payload.
// Payload only updates when a valid item is loaded, so it holds its last value across bubbles.
module add_pipe_stage #(
  parameter type payload_t = logic
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     clr,
  input  logic     load,
  input  logic     in_valid,
  input  payload_t in_data,
  output logic     valid_q,
  output payload_t data_q
);

  logic     valid_d;
  payload_t data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
    if (clr) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/add_pipe_core.sv
// Pipelined WIDTH-bit adder/subtractor with valid/ready on both sides and a handshake counter.
// Arithmetic happens once at stage 0; later stages only move data, collapsing bubbles.
module add_pipe_core
  import add_pipe_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int PIPE_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  add_pipe_if.slave        bus,
  output logic [CNT_W-1:0] txn_cnt
);

  if (PIPE_STAGES < 1 || PIPE_STAGES > MAX_PIPE_STAGES) begin : g_bad_stages
    $error("add_pipe_core: PIPE_STAGES must be in 1..%0d", MAX_PIPE_STAGES);
  end
  if (WIDTH < 1 || CNT_W < 1) begin : g_bad_width
    $error("add_pipe_core: WIDTH and CNT_W must be at least 1");
  end

  typedef struct packed {
    add_op_e        op;
    logic [WIDTH:0] result;
  } payload_t;

  logic [PIPE_STAGES-1:0] v;
  logic [PIPE_STAGES-1:0] load;
  logic [PIPE_STAGES-1:0] up_valid;
  payload_t               data     [PIPE_STAGES];
  payload_t               up_data  [PIPE_STAGES];

  logic       in_ready;
  logic       accept;
  logic       out_hs;
  payload_t   s0_d;
  add_op_e    in_op_e;
  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Ready chain from the output back: a stage may load if it is empty or everything after it moves.
  always_comb begin
    logic nxt;
    load = '0;
    nxt  = bus.out_ready;
    for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
      load[k] = !v[k] || nxt;
      nxt     = load[k];
    end
  end

  assign in_ready = load[0] && !clr;
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    in_op_e = add_op_e'(bus.in_op);
    a_ext   = {1'b0, bus.ina};
    b_ext   = {1'b0, bus.inb};
    s0_d.op = in_op_e;
    case (in_op_e)
      OP_ADD:  s0_d.result = a_ext + b_ext;
      default: s0_d.result = a_ext - b_ext;
    endcase
  end

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign up_valid[k] = accept;
      assign up_data[k]  = s0_d;
    end else begin : g_body
      assign up_valid[k] = v[k-1];
      assign up_data[k]  = data[k-1];
    end

    add_pipe_stage #(
      .payload_t (payload_t)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .load     (load[k]),
      .in_valid (up_valid[k]),
      .in_data  (up_data[k]),
      .valid_q  (v[k]),
      .data_q   (data[k])
    );
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = v[PIPE_STAGES-1];
  assign bus.out       = data[PIPE_STAGES-1].result;
  assign bus.out_op    = data[PIPE_STAGES-1].op;

  assign out_hs = bus.out_valid && bus.out_ready;

  // A handshake coinciding with clr completes downstream but is not counted.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (out_hs) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign txn_cnt = cnt_q;

endmodule

// File: tb/tb_add_pipe_core.sv
// Directed bench for add_pipe_core: carry/borrow, backpressure streaming, counter wrap, clr and async reset.
// Inputs change on the falling edge; outputs are sampled just after it.
module tb_add_pipe_core;

  localparam int WIDTH  = 8;
  localparam int STAGES = 3;
  localparam int CNT_W  = 4;

  logic             clk;
  logic             rst;
  logic             clr;
  logic [CNT_W-1:0] txn_cnt;

  add_pipe_if #(.WIDTH(WIDTH)) bus ();

  add_pipe_core #(
    .WIDTH       (WIDTH),
    .PIPE_STAGES (STAGES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .bus     (bus),
    .txn_cnt (txn_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  logic [WIDTH+1:0] exp_q[$];
  logic [WIDTH+1:0] pend_exp;
  logic [WIDTH+1:0] prev_data;
  logic [CNT_W-1:0] exp_cnt;
  logic             stalled;
  logic             last_acc;
  logic             saw_full;
  int               hs_total;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [WIDTH:0] r);
    bus.in_valid = vld;
    bus.in_op    = op;
    bus.ina      = a;
    bus.inb      = b;
    pend_exp     = {op, r};
  endtask

  // One clock: scoreboard both handshakes, then check counter and hold behaviour.
  task automatic tick();
    logic hs;
    logic was_clr;
    #1;
    last_acc = bus.in_valid && bus.in_ready;
    hs       = bus.out_valid && bus.out_ready;
    was_clr  = clr;
    if (!clr) begin
      check("in_ready", bus.in_ready, (exp_q.size() < STAGES) || bus.out_ready);
      if (!bus.in_ready) saw_full = 1'b1;
    end
    if (stalled) begin
      check("hold_valid", bus.out_valid, 1);
      check("hold_data", {bus.out_op, bus.out}, prev_data);
    end
    if (hs) begin
      if (exp_q.size() == 0) check("spurious_out", bus.out_valid, 0);
      else check("sb_data", {bus.out_op, bus.out}, exp_q.pop_front());
      hs_total++;
    end
    if (last_acc) exp_q.push_back(pend_exp);
    stalled   = bus.out_valid && !bus.out_ready && !clr;
    prev_data = {bus.out_op, bus.out};
    @(posedge clk);
    if (was_clr) begin
      exp_q.delete();
      exp_cnt = '0;
    end else if (hs) begin
      exp_cnt = exp_cnt + 1'b1;
    end
    @(negedge clk);
    check("txn_cnt", txn_cnt, exp_cnt);
  endtask

  logic pat [4];
  int   i, cyc, lat, base, n;
  logic c15, c16, c17;

  initial begin
    pat      = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_cnt  = '0;
    stalled  = 1'b0;
    saw_full = 1'b0;
    hs_total = 0;
    rst      = 1'b1;
    clr      = 1'b0;
    bus.out_ready = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out", bus.out, 0);
    check("rst_out_op", bus.out_op, 0);
    check("rst_txn_cnt", txn_cnt, 0);
    check("rst_in_ready", bus.in_ready, 1);

    // Carry on add, with latency measured from the accept cycle
    drive(1, 0, 8'hFF, 8'h01, 9'h100);
    tick();
    drive(0, 0, 0, 0, 0);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("carry_latency", lat, STAGES);
    check("carry_out", bus.out, 9'h100);
    check("carry_op", bus.out_op, 0);
    tick();
    check("carry_cnt", txn_cnt, 1);
    check("carry_valid_drop", bus.out_valid, 0);

    // Borrow and zero on subtract, back to back
    drive(1, 1, 8'h05, 8'h07, 9'h1FE);
    tick();
    drive(1, 1, 8'h80, 8'h80, 9'h000);
    tick();
    drive(0, 0, 0, 0, 0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("sub_borrow", {bus.out_op, bus.out}, {1'b1, 9'h1FE});
    tick();
    check("sub_zero_valid", bus.out_valid, 1);
    check("sub_zero", {bus.out_op, bus.out}, {1'b1, 9'h000});
    tick();
    check("sub_cnt", txn_cnt, 3);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_idle_cnt", txn_cnt, 0);

    // Stream i+i under a 1-0-0-1 out_ready pattern
    i = 0;
    cyc = 0;
    base = hs_total;
    saw_full = 1'b0;
    while ((i < 10 || exp_q.size() != 0) && cyc < 200) begin
      bus.out_ready = pat[cyc % 4];
      if (i < 10) drive(1, 0, WIDTH'(i), WIDTH'(i), (WIDTH+1)'(2 * i));
      else drive(0, 0, 0, 0, 0);
      tick();
      if (last_acc) i++;
      cyc++;
    end
    drive(0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    check("bp_rx_count", hs_total - base, 10);
    check("bp_cnt", txn_cnt, 10);
    check("bp_saw_full", saw_full, 1);

    // Counter wrap over 17 transactions
    clr = 1'b1;
    tick();
    clr = 1'b0;
    i = 0;
    cyc = 0;
    base = hs_total;
    c15 = 1'b0;
    c16 = 1'b0;
    c17 = 1'b0;
    while ((i < 17 || exp_q.size() != 0) && cyc < 200) begin
      if (i < 17) drive(1, 0, WIDTH'(i), 8'h01, (WIDTH+1)'(i + 1));
      else drive(0, 0, 0, 0, 0);
      tick();
      if (last_acc) i++;
      cyc++;
      n = hs_total - base;
      if (n == 15 && !c15) begin c15 = 1'b1; check("wrap_15", txn_cnt, 15); end
      if (n == 16 && !c16) begin c16 = 1'b1; check("wrap_16", txn_cnt, 0); end
      if (n == 17 && !c17) begin c17 = 1'b1; check("wrap_17", txn_cnt, 1); end
    end
    drive(0, 0, 0, 0, 0);
    check("wrap_done", hs_total - base, 17);

    // clr with the pipeline full and stalled
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      drive(1, 0, WIDTH'(k), WIDTH'(k), (WIDTH+1)'(2 * k));
      tick();
    end
    drive(0, 0, 0, 0, 0);
    check("clr_pre_valid", bus.out_valid, 1);
    clr = 1'b1;
    #1;
    check("clr_in_ready", bus.in_ready, 0);
    tick();
    clr = 1'b0;
    check("clr_out_valid", bus.out_valid, 0);
    check("clr_cnt", txn_cnt, 0);
    bus.out_ready = 1'b1;
    drive(1, 0, 8'h03, 8'h04, 9'h007);
    tick();
    drive(0, 0, 0, 0, 0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("post_clr_sum", {bus.out_op, bus.out}, {1'b0, 9'h007});
    tick();
    check("post_clr_cnt", txn_cnt, 1);

    // Async reset between edges with two in flight
    bus.out_ready = 1'b0;
    drive(1, 0, 8'h10, 8'h20, 9'h030);
    tick();
    drive(1, 0, 8'h30, 8'h40, 9'h070);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    check("pre_rst_valid", bus.out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_out", bus.out, 0);
    check("arst_out_op", bus.out_op, 0);
    check("arst_txn_cnt", txn_cnt, 0);
    check("arst_in_ready", bus.in_ready, 1);
    exp_q.delete();
    exp_cnt = '0;
    stalled = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    base = hs_total;
    repeat (8) tick();
    check("post_rst_quiet", bus.out_valid, 0);
    check("post_rst_no_out", hs_total - base, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
